// File: rtl/hazard_sched.sv
// -----------------------------------------------------------------------------
// hazard_sched
//   Central hazard scheduler for the 5-stage core (F/D/E/M/W). Every cycle it
//   combines the hazard sources into one consistent set of per-stage stall and
//   flush controls. The hazard sources are: load-use, imem/dmem wait, mul/div
//   occupancy, EX redirect and CSR/exception flush.
//
//   Fixed priority, highest first:
//     csr_flush_eff > dmem_wait > mul/div busy > redirect > load-use > imem_wait
//
//   State held across cycles:
//     - a two-state FSM (IDLE / MD_BUSY) that tracks mul/div occupancy, with a
//       timeout counter.
//     - csr_pend, which keeps a CSR flush deferred behind an outstanding
//       data-memory access.
//   All outputs are combinational from state and inputs, and are forced to 0
//   while reset is low.
//
// Ports:
//   clk, reset (async, active-low)
//   id_valid, ra1, ra2                 D-stage operands
//   ex_valid, dstE, ex_memtoreg        E-stage destination / load flag
//   imem_wait, dmem_wait               memory wait
//   md_start, md_done                  multicycle mul/div handshake
//   redirect, csr_flush                flush requests
//   stallF..stallM, flushD..flushM     pipeline register controls
//   md_err                             one-cycle pulse on mul/div timeout
//
// Optional feature (macro HAZARD_PERF_EN):
//   Adds 32-bit counters perf_load_stall, perf_mem_stall, perf_md_stall and
//   perf_flush. Each one counts the cycles in which its rule won arbitration.
// -----------------------------------------------------------------------------
module hazard_sched #(
  parameter int REG_AW     = 5,
  parameter int MD_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] dstE,
  input  logic              ex_memtoreg,
  input  logic              imem_wait,
  input  logic              dmem_wait,
  input  logic              md_start,
  input  logic              md_done,
  input  logic              redirect,
  input  logic              csr_flush,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              md_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_load_stall,
  output logic [31:0]       perf_mem_stall,
  output logic [31:0]       perf_md_stall,
  output logic [31:0]       perf_flush
`endif
);

  typedef enum logic {IDLE = 1'b0, MD_BUSY = 1'b1} state_e;

  localparam logic [6:0] TMO_LAST = 7'(MD_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [6:0] md_cnt_q, md_cnt_d;
  logic       csr_pend_q, csr_pend_d;

  logic csr_flush_eff;
  logic md_busy, md_timeout, md_stall, load_use;
  logic win_csr, win_mem, win_md, win_redir, win_lu, win_imem;

  // A CSR flush cannot be applied while M still waits on dmem. The flush is
  // remembered in csr_pend and fires on the first cycle dmem_wait drops.
  assign csr_flush_eff = (csr_flush | csr_pend_q) & ~dmem_wait;

  assign md_busy    = (state_q == MD_BUSY);
  assign md_timeout = md_busy & (md_cnt_q == TMO_LAST);
  // The done cycle and the timeout cycle both release the pipeline.
  assign md_stall   = md_busy & ~md_done & ~md_timeout;

  assign load_use = ex_valid & ex_memtoreg & id_valid & (dstE != '0) &
                    ((ra1 == dstE) | (ra2 == dstE));

  // One-hot winner of the priority chain. It is gated by reset so that the
  // outputs are 0 while reset is held, whatever the inputs are.
  assign win_csr   = reset & csr_flush_eff;
  assign win_mem   = reset & ~csr_flush_eff & dmem_wait;
  assign win_md    = reset & ~csr_flush_eff & ~dmem_wait & md_stall;
  assign win_redir = reset & ~csr_flush_eff & ~dmem_wait & ~md_stall & redirect;
  assign win_lu    = reset & ~csr_flush_eff & ~dmem_wait & ~md_stall & ~redirect &
                     load_use;
  assign win_imem  = reset & ~csr_flush_eff & ~dmem_wait & ~md_stall & ~redirect &
                     ~load_use & imem_wait;

  // Exactly one rule drives the outputs, so a stage is never stalled and
  // flushed in the same cycle. An imem_wait that loses to mul/div or load-use
  // still has stallF set by the winning rule, and D is held rather than
  // flushed.
  assign stallF = win_mem | win_md | win_lu | win_imem;
  assign stallD = win_mem | win_md | win_lu;
  assign stallE = win_mem | win_md;
  assign stallM = win_mem;
  assign flushD = win_csr | win_redir | win_imem;
  assign flushE = win_csr | win_redir | win_lu;
  assign flushM = win_csr | win_md;
  assign md_err = reset & md_timeout & ~md_done;

  always_comb begin
    state_d    = state_q;
    md_cnt_d   = md_cnt_q;
    csr_pend_d = csr_pend_q;

    if (csr_flush_eff) begin
      csr_pend_d = 1'b0;
    end else if (csr_flush & dmem_wait) begin
      csr_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (md_start & ex_valid & ~csr_flush_eff) begin
          state_d  = MD_BUSY;
          md_cnt_d = '0;
        end
      end
      MD_BUSY: begin
        if (md_cnt_q != 7'h7F) begin
          md_cnt_d = md_cnt_q + 7'd1;
        end
        if (md_done | md_timeout | csr_flush_eff) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      md_cnt_q   <= '0;
      csr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      md_cnt_q   <= md_cnt_d;
      csr_pend_q <= csr_pend_d;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_load_stall <= '0;
      perf_mem_stall  <= '0;
      perf_md_stall   <= '0;
      perf_flush      <= '0;
    end else begin
      if (win_lu)  perf_load_stall <= perf_load_stall + 32'd1;
      if (win_mem) perf_mem_stall  <= perf_mem_stall + 32'd1;
      if (win_md)  perf_md_stall   <= perf_md_stall + 32'd1;
      if (win_csr) perf_flush      <= perf_flush + 32'd1;
    end
  end
`endif

endmodule
